// File: rtl/fp_mul_pack_stage.sv
// Back end of the single-precision multiplier: sign/exponent, class detection, IEEE-754 packing.
// Two-stage valid/ready pipeline; define FPMUL_FLAG_COUNT_EN to add saturating flag counters.
module fp_mul_pack_stage #(
  parameter int BIAS  = 127,
  parameter int EXP_W = 10   // must be >= 10 to hold the full signed exponent sum
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        normalised,
  input  logic [22:0] product_mantissa,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        exception
`ifdef FPMUL_FLAG_COUNT_EN
  ,
  output logic [15:0] ovf_count,
  output logic [15:0] unf_count,
  output logic [15:0] exc_count
`endif
);

  localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);

  // S1 state
  logic                    r_s1_valid;
  logic                    r_s1_sign;
  logic signed [EXP_W-1:0] r_s1_esum;
  logic [22:0]             r_s1_mant;
  logic                    r_s1_zero;
  logic                    r_s1_exc;

  // S1 combinational inputs
  logic signed [EXP_W-1:0] w_ea, w_eb, w_norm, w_esum;
  logic                    w_a_zero, w_b_zero, w_exc;

  // S2 next-state
  logic        w_s2_load;
  logic [31:0] w_res;
  logic        w_ovf, w_unf, w_exc_out;

  assign w_s2_load = !out_valid | out_ready;
  assign in_ready  = !r_s1_valid | w_s2_load;

  assign w_ea     = {{(EXP_W-8){1'b0}}, a_operand[30:23]};
  assign w_eb     = {{(EXP_W-8){1'b0}}, b_operand[30:23]};
  assign w_norm   = {{(EXP_W-1){1'b0}}, normalised};
  assign w_esum   = w_ea + w_eb - EXP_BIAS + w_norm;
  assign w_a_zero = (a_operand[30:0] == 31'd0);
  assign w_b_zero = (b_operand[30:0] == 31'd0);
  assign w_exc    = (a_operand[30:23] == 8'hFF) | (b_operand[30:23] == 8'hFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_esum  <= '0;
      r_s1_mant  <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_exc   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= a_operand[31] ^ b_operand[31];
        r_s1_esum <= w_esum;
        r_s1_mant <= product_mantissa;
        r_s1_zero <= w_a_zero | w_b_zero;
        r_s1_exc  <= w_exc;
      end
    end
  end

  // Classification priority: NaN operand, zero operand, overflow, underflow, normal.
  always_comb begin
    w_res     = {r_s1_sign, r_s1_esum[7:0], r_s1_mant};
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    w_exc_out = 1'b0;
    if (r_s1_exc) begin
      w_res     = {r_s1_sign, 8'hFF, 23'h400000};
      w_exc_out = 1'b1;
    end else if (r_s1_zero) begin
      w_res = {r_s1_sign, 31'd0};
    end else if (r_s1_esum >= EXP_MAX) begin
      w_res = {r_s1_sign, 8'hFF, 23'd0};
      w_ovf = 1'b1;
    end else if (r_s1_esum <= EXP_ZERO) begin
      w_res = {r_s1_sign, 31'd0};
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else if (w_s2_load) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        result    <= w_res;
        overflow  <= w_ovf;
        underflow <= w_unf;
        exception <= w_exc_out;
      end
    end
  end

`ifdef FPMUL_FLAG_COUNT_EN
  logic w_fire;
  assign w_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count <= '0;
      unf_count <= '0;
      exc_count <= '0;
    end else if (w_fire) begin
      if (overflow  && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      if (underflow && unf_count != 16'hFFFF) unf_count <= unf_count + 16'd1;
      if (exception && exc_count != 16'hFFFF) exc_count <= exc_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fp_mul_pack_stage.md
Name: fp_mul_pack_stage

Overview:
- Back end of the single-precision multiplier. Sits directly downstream of the mantissa stage.
- Consumes the raw operands plus the stage's normalised flag and 23-bit product mantissa.
- Computes result sign and biased exponent, and detects zero, overflow, underflow and exception.
- Packs the IEEE-754 word through a 2-deep valid/ready pipeline with full backpressure.

Parameters:
- BIAS, 127: exponent bias subtracted from the exponent sum.
- EXP_W, 10: internal signed exponent width; must be at least 10.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept a beat
- a_operand  input  32  operand A, IEEE-754 single
- b_operand  input  32  operand B, IEEE-754 single
- normalised  input  1  mantissa-stage flag; product bit 47 was set
- product_mantissa  input  23  mantissa-stage rounded fraction
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  32  packed product
- overflow  output  1  result saturated to infinity
- underflow  output  1  result flushed to zero
- exception  output  1  an operand had exponent 255

Behaviour:
- Clocking and reset:
  - Single clock. All state changes on the rising edge of clk.
  - When reset=1 at an edge: s1_valid=0, s2_valid=0, out_valid=0, result=0, overflow=0, underflow=0, exception=0.
  - in_ready is combinational and reads 1 in the cycle after reset.
  - Reset mid-operation drops all in-flight beats. There is no partial output.
- Pipeline:
  - Stage S1 registers sign, exponent sum, mantissa and class flags.
  - Stage S2 holds the packed result and drives the outputs.
  - Latency with no stall: 2 cycles from the in_valid&in_ready edge to out_valid.
  - Throughput: 1 beat per cycle.
- Handshake:
  - S2 is loaded when (!s2_valid | out_ready).
  - S1 advances when S2 loads.
  - in_ready = !s1_valid | s2_advance.
  - A beat is accepted when in_valid & in_ready. out_valid and result stay stable while out_valid & !out_ready.
  - A simultaneous accept and emit in the same cycle must lose no beat and duplicate no beat.
- S1 arithmetic:
  - sign = a[31]^b[31].
  - esum = a[30:23] + b[30:23] - BIAS + normalised, computed signed at EXP_W bits.
  - a_zero = (a[30:0]==0); b_zero likewise.
  - exc = (a[30:23]==255) | (b[30:23]==255).
- S2 classification, in priority order:
  1. exc: result = {sign, 8'hFF, 23'h400000} (quiet NaN); exception=1.
  2. a_zero|b_zero: result = {sign, 31'd0}; all flags 0.
  3. esum >= 255: result = {sign, 8'hFF, 23'd0}; overflow=1.
  4. esum <= 0: result = {sign, 31'd0}; underflow=1. No subnormal output.
  5. Otherwise: result = {sign, esum[7:0], product_mantissa}.
- Flag timing: flags are registered with result and are valid only while out_valid=1. They clear on the next loaded beat.
- Mantissa carry-out from rounding is not re-normalised here; it is the mantissa stage's responsibility.

Optional Feature:
- Macro: FPMUL_FLAG_COUNT_EN.
- When defined:
  - Add outputs ovf_count[15:0], unf_count[15:0] and exc_count[15:0].
  - Each counter increments by 1 on every out_valid&out_ready handshake whose respective flag is set.
  - Counters saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- a=3FC00000, b=40000000, normalised=0, mantissa=400000, out_ready=1 -> result=40400000 two cycles later, all flags 0.
- a=7F000000, b=40000000, normalised=0, mantissa=0 -> result=7F800000, overflow=1.
- a=00800000, b=80800000, mantissa=0 -> result=80000000, underflow=1.
- a=00000000, b=BF800000 -> result=80000000, flags 0. Also a=7FC00000, b=3F800000 -> result=7FC00000, exception=1.
- Back-to-back beats 1.5×2 then 2×2 with out_ready held 0 for 3 cycles:
  - in_ready=0 once both stages are full.
  - Output holds 40400000 stable until out_ready=1, then emits 40800000 next. No loss or duplicate.
- Assert reset with 2 beats in flight -> out_valid=0 next cycle and no stale result emitted afterwards. With FPMUL_FLAG_COUNT_EN, all counters read 0.
